// File: rtl/logistic_map_engine.sv
// Multi-channel logistic-map iterator: x <- mu*x*(1-x) in unsigned fixed point,
// one shared multiplier time-multiplexed over all channels, with a per-sweep snapshot.
module logistic_map_engine #(
    parameter int unsigned      FRAC_W    = 16,
    parameter int unsigned      CHANNELS  = 7,
    parameter logic [FRAC_W:0]  SEED_BASE = 17'h08240,
    localparam int unsigned     X_W       = FRAC_W + 1,
    localparam int unsigned     MU_W      = FRAC_W + 2,
    localparam int unsigned     CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              free_run,
    input  logic [15:0]       iter_count,
    input  logic [MU_W-1:0]   mu,
    input  logic              seed_wr,
    input  logic [CH_W-1:0]   seed_addr,
    input  logic [X_W-1:0]    seed_data,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [X_W-1:0]    rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sweep_cnt
);

    localparam int unsigned     P_W     = 2 * FRAC_W + 2;
    localparam logic [1:0]      S_IDLE  = 2'd0;
    localparam logic [1:0]      S_RUN   = 2'd1;
    localparam logic [1:0]      S_FIN   = 2'd2;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [X_W-1:0]  ONE     = X_W'(1) << FRAC_W;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [X_W-1:0]   x_q    [CHANNELS];
    logic [X_W-1:0]   snap_q [CHANNELS];
    logic [CH_W-1:0]  ch;
    logic             phase;
    logic [MU_W-1:0]  term_r;
    logic [MU_W-1:0]  mu_r;
    logic [15:0]      n_r;
    logic             fr_r;

    logic             busy_nxt;
    logic             done_nxt;
    logic             run_start;
    logic             iterate;
    logic             sweep_end;
    logic             seed_ok;

    logic [X_W-1:0]   x_cur;
    logic [X_W-1:0]   one_minus;
    logic [MU_W-1:0]  mul_a;
    logic [MU_W-1:0]  mul_b;
    logic [P_W-1:0]   product;
    logic [MU_W-1:0]  prod_hi;
    logic [X_W-1:0]   x_new;

    // Shared multiplier: phase 0 forms x*(1-x), phase 1 scales the term by mu
    always_comb begin
        x_cur     = x_q[ch];
        one_minus = ONE - x_cur;
        mul_a     = phase ? mu_r   : MU_W'(x_cur);
        mul_b     = phase ? term_r : MU_W'(one_minus);
        product   = P_W'(mul_a) * P_W'(mul_b);
        prod_hi   = MU_W'(product >> FRAC_W);
        x_new     = prod_hi[X_W-1:0];
    end

    assign seed_ok = (state == S_IDLE) && seed_wr && (32'(seed_addr) < CHANNELS);

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        run_start = 1'b0;
        iterate   = 1'b0;
        sweep_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    run_start = 1'b1;
                    busy_nxt  = (iter_count != 16'd0) || free_run;
                end
            end
            S_RUN: begin
                // A zero-length counted run passes straight through without iterating
                if ((n_r == 16'd0) && !fr_r) begin
                    state_nxt = S_FIN;
                    done_nxt  = 1'b1;
                end else begin
                    iterate  = 1'b1;
                    busy_nxt = 1'b1;
                    if (phase && (ch == LAST_CH)) begin
                        sweep_end = 1'b1;
                        if (fr_r ? !free_run : ((sweep_cnt + 16'd1) == n_r)) begin
                            state_nxt = S_FIN;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers and outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ch        <= '0;
            phase     <= 1'b0;
            term_r    <= '0;
            mu_r      <= '0;
            n_r       <= '0;
            fr_r      <= 1'b0;
            sweep_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (run_start) begin
                mu_r      <= mu;
                n_r       <= iter_count;
                fr_r      <= free_run;
                ch        <= '0;
                phase     <= 1'b0;
                sweep_cnt <= '0;
            end
            if (iterate) begin
                if (!phase) begin
                    term_r <= prod_hi;
                    phase  <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    ch    <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
                end
            end
            if (sweep_end) begin
                sweep_cnt <= sweep_cnt + 16'd1;
            end
        end
    end

    // Trajectory state; seed writes and iteration never coincide
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                x_q[i] <= SEED_BASE + X_W'(i);
            end
        end else begin
            if (seed_ok) begin
                x_q[seed_addr] <= seed_data;
            end
            if (iterate && phase) begin
                x_q[ch] <= x_new;
            end
        end
    end

    // Frame snapshot, refreshed only when a sweep completes
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                snap_q[i] <= SEED_BASE + X_W'(i);
            end
        end else if (sweep_end) begin
            for (int i = 0; i < int'(CHANNELS) - 1; i++) begin
                snap_q[i] <= x_q[i];
            end
            snap_q[CHANNELS-1] <= x_new;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < CHANNELS) begin
            rd_data = snap_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_logistic_map_engine.sv
// Randomised self-checking bench for logistic_map_engine against an arithmetic
// model of the map, sweep timing and snapshot behaviour.
module tb_logistic_map_engine;

    localparam int unsigned CHANNELS = 7;
    localparam int unsigned SWEEP    = 2 * CHANNELS;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        free_run;
    logic [15:0] iter_count;
    logic [17:0] mu;
    logic        seed_wr;
    logic [2:0]  seed_addr;
    logic [16:0] seed_data;
    logic [2:0]  rd_addr;
    logic [16:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] sweep_cnt;

    int checks   = 0;
    int failures = 0;

    longint mx    [CHANNELS];
    longint msnap [CHANNELS];

    logistic_map_engine dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .free_run   (free_run),
        .iter_count (iter_count),
        .mu         (mu),
        .seed_wr    (seed_wr),
        .seed_addr  (seed_addr),
        .seed_data  (seed_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .sweep_cnt  (sweep_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // x <- mu*x*(1-x) with both products truncated to FRAC_W=16 fractional bits
    function automatic longint map_step(input longint x, input longint m);
        longint term;
        term = ((x * (65536 - x)) >> 16) & 64'h3FFFF;
        return ((m * term) >> 16) & 64'h1FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(CHANNELS); i++) begin
            mx[i]    = 64'h08240 + longint'(i);
            msnap[i] = mx[i];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic seed_ch(input int addr, input longint data);
        seed_addr = 3'(addr);
        seed_data = 17'(data);
        seed_wr   = 1'b1;
        tick();
        seed_wr = 1'b0;
        if (addr < int'(CHANNELS)) mx[addr] = data;
    endtask

    task automatic check_snaps(input string tag);
        for (int i = 0; i < int'(CHANNELS); i++) begin
            rd_addr = 3'(i);
            #1;
            check(tag, 64'(rd_data), 64'(msnap[i]));
        end
    endtask

    // Counted run; optionally with a seed write in the start cycle
    task automatic run_counted(input longint m, input int n, input bit with_seed,
                               input int s_addr, input longint s_data);
        longint hist [0:8][0:6];
        int     c;
        int     ra;
        if (with_seed && s_addr < int'(CHANNELS)) mx[s_addr] = s_data;
        for (int i = 0; i < int'(CHANNELS); i++) hist[0][i] = msnap[i];
        for (int k = 1; k <= n; k++) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                mx[i]      = map_step(mx[i], m);
                hist[k][i] = mx[i];
            end
        end
        mu         = 18'(m);
        iter_count = 16'(n);
        free_run   = 1'b0;
        start      = 1'b1;
        if (with_seed) begin
            seed_wr   = 1'b1;
            seed_addr = 3'(s_addr);
            seed_data = 17'(s_data);
        end
        tick();
        start   = 1'b0;
        seed_wr = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        c = 0;
        while (busy === 1'b1 && c < n * int'(SWEEP) + 20) begin
            ra      = int'($urandom_range(0, CHANNELS - 1));
            rd_addr = 3'(ra);
            #1;
            check("run_snap", 64'(rd_data), 64'(hist[c / int'(SWEEP)][ra]));
            check("run_sweep_cnt", 64'(sweep_cnt), 64'(c / int'(SWEEP)));
            check("run_no_done", 64'(done), 64'd0);
            tick();
            c++;
        end
        check("busy_cycles", 64'(c), 64'(n * int'(SWEEP)));
        check("done_pulse", 64'(done), 64'd1);
        check("final_sweep_cnt", 64'(sweep_cnt), 64'(n));
        for (int i = 0; i < int'(CHANNELS); i++) msnap[i] = hist[n][i];
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        check_snaps("final_snap");
    endtask

    task automatic run_free(input longint m, input int hold);
        int c;
        int exp_sweeps;
        exp_sweeps = (hold + int'(SWEEP) - 1) / int'(SWEEP);
        mu         = 18'(m);
        iter_count = 16'd1;
        free_run   = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (busy === 1'b1 && c < 400) begin
            check("free_no_done", 64'(done), 64'd0);
            tick();
            c++;
            start     = (c == 30);
            seed_wr   = (c == 40);
            seed_addr = 3'd2;
            seed_data = 17'h01234;
            if (c == hold - 1) free_run = 1'b0;
        end
        start   = 1'b0;
        seed_wr = 1'b0;
        for (int k = 0; k < exp_sweeps; k++)
            for (int i = 0; i < int'(CHANNELS); i++) mx[i] = map_step(mx[i], m);
        for (int i = 0; i < int'(CHANNELS); i++) msnap[i] = mx[i];
        check("free_busy_cycles", 64'(c), 64'(exp_sweeps * int'(SWEEP)));
        check("free_done", 64'(done), 64'd1);
        check("free_sweep_cnt", 64'(sweep_cnt), 64'(exp_sweeps));
        tick();
        check("free_done_one_cycle", 64'(done), 64'd0);
        check("free_idle_busy", 64'(busy), 64'd0);
        check_snaps("free_snap");
    endtask

    initial begin
        bit seen_done;
        RST        = 1'b0;
        start      = 1'b0;
        free_run   = 1'b0;
        iter_count = '0;
        mu         = '0;
        seed_wr    = 1'b0;
        seed_addr  = '0;
        seed_data  = '0;
        rd_addr    = '0;
        model_reset();
        repeat (3) tick();
        RST = 1'b1;
        tick();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sweep_cnt", 64'(sweep_cnt), 64'd0);
        check_snaps("rst_snap");
        rd_addr = 3'd7;
        #1;
        check("rd_out_of_range", 64'(rd_data), 64'd0);

        // Fixed point at x=0.5, mu=2
        seed_ch(0, 64'h8000);
        run_counted(64'h20000, 3, 1'b0, 0, 0);
        rd_addr = 3'd0;
        #1;
        check("fixed_x0", 64'(rd_data), 64'h8000);

        // Collapse at mu just under 4
        seed_ch(0, 64'h8000);
        run_counted(64'h3FFFF, 1, 1'b0, 0, 0);
        rd_addr = 3'd0;
        #1;
        check("collapse_1", 64'(rd_data), 64'hFFFF);
        run_counted(64'h3FFFF, 1, 1'b0, 0, 0);
        rd_addr = 3'd0;
        #1;
        check("collapse_2", 64'(rd_data), 64'h0);
        run_counted(64'h3FFFF, 1, 1'b0, 0, 0);
        rd_addr = 3'd0;
        #1;
        check("collapse_3", 64'(rd_data), 64'h0);

        // Zero-count run
        mu         = 18'h2ABCD;
        iter_count = 16'd0;
        free_run   = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("zero_busy_0", 64'(busy), 64'd0);
        check("zero_done_0", 64'(done), 64'd0);
        tick();
        check("zero_done_1", 64'(done), 64'd1);
        check("zero_busy_1", 64'(busy), 64'd0);
        tick();
        check("zero_done_2", 64'(done), 64'd0);
        check("zero_sweep_cnt", 64'(sweep_cnt), 64'd0);
        check_snaps("zero_snap");

        // Out-of-range seed address, then a seed write coinciding with start
        seed_ch(7, 64'h1FFFF);
        run_counted(64'h3A000, 2, 1'b1, 3, 64'h05555);

        // Free run with ignored start/seed during RUN
        run_free(64'h39000, 100);

        // Randomised counted runs
        for (int r = 0; r < 6; r++) begin
            int nseeds;
            nseeds = int'($urandom_range(0, 3));
            for (int s = 0; s < nseeds; s++)
                seed_ch(int'($urandom_range(0, CHANNELS - 1)), longint'($urandom_range(0, 65536)));
            run_counted(longint'($urandom_range(0, 18'h3FFFF)), int'($urandom_range(1, 4)),
                        1'b0, 0, 0);
        end

        // Reset in the middle of a 5-sweep run
        mu         = 18'h33333;
        iter_count = 16'd5;
        free_run   = 1'b0;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        seen_done = 1'b0;
        repeat (19) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        model_reset();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_sweep_cnt", 64'(sweep_cnt), 64'd0);
        check_snaps("midrst_snap");
        repeat (3) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst_no_done", 64'(seen_done), 64'd0);
        run_counted(64'h2C000, 2, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
